// File: rtl/angle_range_reducer.sv
// Purpose : reduces an integer angle (degrees) mod 360 and folds it into 0..90 plus a 2-bit quadrant for the trig LUTs.
// Latency : ITER+1 edges from acceptance to out_valid (ITER+2 with ANGLE_SIGNED_EN defined).
// Backpr. : in_ready is high only when idle; in_valid is ignored while busy; the output pulse is not held.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous reset, ACTIVE-HIGH despite the name (1 at an edge clears the block)
//   in_valid   angle_in is valid; accepted when in_ready is also high
//   in_ready   block is idle (forced low while reset_n is asserted)
//   angle_in   angle in degrees (unsigned, or two's complement with ANGLE_SIGNED_EN)
//   out_valid  one-cycle pulse, drives the LUT enable
//   angle_out  folded angle 0..90, held until the next result
//   quadrant   0..3 LUT quadrant code, held until the next result
//
// Optional feature macro: ANGLE_SIGNED_EN (signed input, adds a NEG_FIX cycle).

module angle_range_reducer #(
  parameter int DATA_WIDTH = 16,
  parameter int ITER       = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] angle_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] angle_out,
  output logic [1:0]            quadrant
);

  // Remainder is wide enough to hold 360 shifted by the largest step.
  localparam int RW = DATA_WIDTH + 9;
  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [RW-1:0] MOD = RW'(360);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REDUCE  = 2'd1,
    FOLD    = 2'd2
`ifdef ANGLE_SIGNED_EN
    ,
    NEG_FIX = 2'd3
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           r_q, r_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   angle_out_q, angle_out_d;
  logic [1:0]              quadrant_q, quadrant_d;
`ifdef ANGLE_SIGNED_EN
  logic                    neg_q, neg_d;
  logic [DATA_WIDTH-1:0]   mag;
`endif

  logic [RW-1:0]           sub;
  logic [8:0]              r9;
  logic [8:0]              fold_ang;
  logic [1:0]              fold_q;

  assign in_ready  = (state_q == IDLE) && !reset_n;
  assign out_valid = out_valid_q;
  assign angle_out = angle_out_q;
  assign quadrant  = quadrant_q;

  // Restoring step divisor for the current iteration.
  assign sub = MOD << k_q;

  // Once reduction finishes r < 360, so the low 9 bits carry the whole value.
  assign r9 = r_q[8:0];

  always_comb begin
    fold_ang = r9;
    fold_q   = 2'd0;
    if (r9 < 9'd90) begin
      fold_ang = r9;
      fold_q   = 2'd0;
    end else if (r9 < 9'd180) begin
      fold_ang = 9'd180 - r9;
      fold_q   = 2'd1;
    end else if (r9 < 9'd270) begin
      fold_ang = r9 - 9'd180;
      fold_q   = 2'd2;
    end else begin
      fold_ang = 9'd360 - r9;
      fold_q   = 2'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    k_d         = k_q;
    out_valid_d = 1'b0;
    angle_out_d = angle_out_q;
    quadrant_d  = quadrant_q;
`ifdef ANGLE_SIGNED_EN
    neg_d       = neg_q;
    // Magnitude of a negative input; the most negative value still fits unsigned.
    mag         = angle_in[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - angle_in) : angle_in;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
`ifdef ANGLE_SIGNED_EN
          neg_d = angle_in[DATA_WIDTH-1];
          r_d   = RW'(mag);
`else
          r_d   = RW'(angle_in);
`endif
          k_d     = KW'(ITER - 1);
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        if (r_q >= sub) begin
          r_d = r_q - sub;
        end
        if (k_q == '0) begin
`ifdef ANGLE_SIGNED_EN
          state_d = NEG_FIX;
`else
          state_d = FOLD;
`endif
        end else begin
          k_d = k_q - KW'(1);
        end
      end

`ifdef ANGLE_SIGNED_EN
      // Convert the magnitude remainder into a true modulo for negative inputs.
      NEG_FIX: begin
        if (neg_q && (r_q != '0)) begin
          r_d = MOD - r_q;
        end
        state_d = FOLD;
      end
`endif

      FOLD: begin
        out_valid_d = 1'b1;
        angle_out_d = DATA_WIDTH'(fold_ang);
        quadrant_d  = fold_q;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      angle_out_q <= '0;
      quadrant_q  <= 2'd0;
`ifdef ANGLE_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      angle_out_q <= angle_out_d;
      quadrant_q  <= quadrant_d;
`ifdef ANGLE_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_angle_range_reducer.sv
// Purpose : randomized + directed bench for angle_range_reducer against a modulo/fold reference model.
// Latency : expects out_valid ITER+1 edges after acceptance (ITER+2 with ANGLE_SIGNED_EN).
// Backpr. : drives in_valid only when in_ready, optionally holding it high while busy.

module tb_angle_range_reducer;

  localparam int DW   = 16;
  localparam int ITER = 8;
`ifdef ANGLE_SIGNED_EN
  localparam int LAT  = ITER + 2;
`else
  localparam int LAT  = ITER + 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] angle_in;
  logic          out_valid;
  logic [DW-1:0] angle_out;
  logic [1:0]    quadrant;

  int checks = 0;
  int errors = 0;

  angle_range_reducer #(
    .DATA_WIDTH(DW),
    .ITER      (ITER)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .angle_in (angle_in),
    .out_valid(out_valid),
    .angle_out(angle_out),
    .quadrant (quadrant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: true modulo 360 of the input value, then fold by quadrant.
  function automatic void ref_fold(input logic [DW-1:0] a, output int ang, output int q);
    int m;
`ifdef ANGLE_SIGNED_EN
    m = int'($signed(a)) % 360;
    if (m < 0) m += 360;
`else
    m = int'(a) % 360;
`endif
    case (m / 90)
      0:       begin q = 0; ang = m;       end
      1:       begin q = 1; ang = 180 - m; end
      2:       begin q = 2; ang = m - 180; end
      default: begin q = 3; ang = 360 - m; end
    endcase
  endfunction

  // Entered and left on a falling edge.
  task automatic run_angle(input logic [DW-1:0] a, input bit hold_valid, input string tag);
    int exp_ang, exp_q, pulse_at, pulses, waited;
    bit busy_ok;
    ref_fold(a, exp_ang, exp_q);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    in_valid = 1'b1;
    angle_in = a;
    @(negedge clk);
    if (hold_valid) angle_in = DW'($urandom);
    else            in_valid = 1'b0;
    pulses   = 0;
    pulse_at = -1;
    busy_ok  = 1'b1;
    for (int c = 0; c <= LAT + 3; c++) begin
      if (out_valid) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
      if (c < LAT && in_ready) busy_ok = 1'b0;
      if (c == LAT) in_valid = 1'b0;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, pulse_at, LAT);
    check_eq({tag, "_pulses"},  pulses, 1);
    check_eq({tag, "_busy"},    int'(busy_ok), 1);
    check_eq({tag, "_angle"},   int'(angle_out), exp_ang);
    check_eq({tag, "_quad"},    int'(quadrant), exp_q);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    angle_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready_low", int'(in_ready), 0);
    check_eq("rst_out_valid",    int'(out_valid), 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready",  int'(in_ready), 1);
    check_eq("post_rst_out_valid", int'(out_valid), 0);
    check_eq("post_rst_angle",     int'(angle_out), 0);
    check_eq("post_rst_quad",      int'(quadrant), 0);

    run_angle(DW'(45),    1'b0, "a45");
    run_angle(DW'(135),   1'b1, "a135_hold");
    run_angle(DW'(180),   1'b0, "a180");
    run_angle(DW'(270),   1'b1, "a270_hold");
    run_angle(DW'(359),   1'b0, "a359");
    run_angle(DW'(65535), 1'b0, "a65535");
    run_angle(DW'(90),    1'b0, "a90");

    // Reset in the middle of a reduction: no pulse, outputs cleared.
    in_valid = 1'b1;
    angle_in = DW'(200);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_angle",     int'(angle_out), 0);
    check_eq("midrst_quad",      int'(quadrant), 0);
    check_eq("midrst_in_ready",  int'(in_ready), 0);
    reset_n = 1'b0;
    pulses  = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check_eq("midrst_no_pulse", pulses, 0);
    run_angle(DW'(200), 1'b0, "a200");

    run_angle(DW'(0),   1'b0, "a0");
    run_angle(DW'(360), 1'b0, "a360");
    run_angle(DW'(719), 1'b1, "a719");
    run_angle(DW'(720), 1'b0, "a720");
`ifdef ANGLE_SIGNED_EN
    run_angle(DW'(-30),  1'b0, "neg30");
    run_angle(DW'(-360), 1'b0, "neg360");
    run_angle(DW'(100),  1'b0, "pos100");
    run_angle(DW'(-32768), 1'b0, "negmax");
`endif

    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] a;
      if (i % 4 == 0) a = DW'($urandom_range(0, 719));
      else            a = DW'($urandom);
      run_angle(a, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
